wb_write_queue: RTL and testbench

//   Writer side of the 32x64 integer register file: collects results from the ALU and the

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/wb_write_queue_if.sv | 48 ++++
 rtl/wb_fifo.sv | 57 +++++
 rtl/wb_write_queue.sv | 101 ++++++++++
 tb/tb_wb_write_queue.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-pipeline types: register-file geometry and the writeback entry record.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // x0 is hardwired to zero, so it never counts as an in-flight destination.
  function automatic logic rd_match(input reg_addr_t entry_rd, input reg_addr_t query);
    return (query != '0) && (entry_rd == query);
  endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Bus bundle for the writeback queue: two result producers, the register-file write port,
// and the pending-write lookup used by decode.
interface wb_write_queue_if;
  import riscv_pkg::*;

  // Producers: a transfer happens in any cycle where valid && ready; valid must not be
  // derived from ready, and offered rd/data must stay stable while valid is held.
  logic            mem_valid;
  logic            mem_ready;
  reg_addr_t       mem_rd;
  logic [XLEN-1:0] mem_data;

  logic            alu_valid;
  logic            alu_ready;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            reg_write;
  reg_addr_t       rd;
  logic [XLEN-1:0] write_data;

  reg_addr_t       query_rs;
  logic            pend_hit;
  logic [XLEN-1:0] pend_data;

  logic [7:0]      dbg_count;

  modport master (
    output mem_valid, mem_rd, mem_data,
    output alu_valid, alu_rd, alu_data,
    output query_rs,
    input  mem_ready, alu_ready,
    input  reg_write, rd, write_data,
    input  pend_hit, pend_data,
    input  dbg_count
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data,
    input  alu_valid, alu_rd, alu_data,
    input  query_rs,
    output mem_ready, alu_ready,
    output reg_write, rd, write_data,
    output pend_hit, pend_data,
    output dbg_count
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order circular buffer with two ordered push lanes and one pop; exposes every slot in
// age order (index 0 = head) so the owner can search for in-flight destinations.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0,
  input  wb_entry_t     push0_entry,
  input  logic          push1,
  input  wb_entry_t     push1_entry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [DEPTH-1:0] entry_valid,
  output wb_entry_t     entry [DEPTH]
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Lane 0 is always the older entry; lane 1 lands behind it when both fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push0) begin
        mem[wr_ptr] <= push0_entry;
      end
      if (push1) begin
        mem[push0 ? wr_ptr + PW'(1) : wr_ptr] <= push1_entry;
      end
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry[i]       = mem[rd_ptr + PW'(i)];
      entry_valid[i] = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Writeback queue: accepts ALU and load results, drains one register-file write per cycle,
// and answers "is this source register still being written, and with what value".
module wb_write_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  wb_write_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M2_C = CW'(DEPTH - 2);

  logic [CW-1:0]    count;
  logic [DEPTH-1:0] entry_valid;
  wb_entry_t        entry [DEPTH];

  logic      mem_ready;
  logic      alu_ready;
  logic      push0;
  logic      push1;
  logic      pop;
  wb_entry_t mem_entry;
  wb_entry_t alu_entry;

  logic            out_valid;
  reg_addr_t       out_rd;
  logic [XLEN-1:0] out_data;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  // With one slot left the load unit gets it.
  always_comb begin
    mem_ready = (count < DEPTH_C);
    alu_ready = bus.mem_valid ? (count <= DEPTH_M2_C) : (count < DEPTH_C);
  end

  // Writes to x0 complete the handshake but are never enqueued.
  always_comb begin
    mem_entry = '{rd: bus.mem_rd, data: bus.mem_data};
    alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};
    push0     = bus.mem_valid && mem_ready && (bus.mem_rd != '0);
    push1     = bus.alu_valid && alu_ready && (bus.alu_rd != '0);
    pop       = (count != '0);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push0       (push0),
    .push0_entry (mem_entry),
    .push1       (push1),
    .push1_entry (alu_entry),
    .pop         (pop),
    .count       (count),
    .entry_valid (entry_valid),
    .entry       (entry)
  );

  // rd/write_data keep their last value while idle; only the strobe drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_rd    <= entry[0].rd;
      out_data  <= entry[0].data;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Search oldest to youngest so a later match overrides; the write port is older than
  // every queued entry and is therefore considered first.
  always_comb begin
    bus.pend_hit  = 1'b0;
    bus.pend_data = '0;
    if (out_valid && rd_match(out_rd, bus.query_rs)) begin
      bus.pend_hit  = 1'b1;
      bus.pend_data = out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && rd_match(entry[i].rd, bus.query_rs)) begin
        bus.pend_hit  = 1'b1;
        bus.pend_data = entry[i].data;
      end
    end
  end

  assign bus.mem_ready  = mem_ready;
  assign bus.alu_ready  = alu_ready;
  assign bus.reg_write  = out_valid;
  assign bus.rd         = out_rd;
  assign bus.write_data = out_data;
  assign bus.dbg_count  = 8'(count);

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: a hand-derived vector table, randomized traffic against a
// queue-level reference model, and a mid-stream reset sequence.
module tb_wb_write_queue;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam int NV    = 17;

  logic clk;
  logic reset;

  wb_write_queue_if bus ();

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  wb_entry_t        model_q[$];
  logic [68:0]      exp_q[$];
  bit               m_out_valid;
  logic [4:0]       m_out_rd;
  logic [63:0]      m_out_data;

  function automatic void model_reset();
    model_q.delete();
    exp_q.delete();
    m_out_valid = 1'b0;
    m_out_rd    = '0;
    m_out_data  = '0;
  endfunction

  function automatic void model_pend(input logic [4:0] q, output bit hit, output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
    if (q == 5'd0) return;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].rd == q) begin
        hit = 1'b1;
        d   = model_q[i].data;
        return;
      end
    end
    if (m_out_valid && m_out_rd == q) begin
      hit = 1'b1;
      d   = m_out_data;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.query_rs  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_reg_write", 64'(bus.reg_write), 64'd0);
    chk("rst_rd", 64'(bus.rd), 64'd0);
    chk("rst_write_data", bus.write_data, 64'd0);
    chk("rst_pend_hit", 64'(bus.pend_hit), 64'd0);
    chk("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    chk("rst_count", 64'(bus.dbg_count), 64'd0);
    reset = 1'b1;
  endtask

  // One cycle against the model; called just after a negedge with inputs already driven.
  task automatic model_tick(output bit m_taken, output bit a_taken);
    int          free;
    bit          e_mr, e_ar, e_hit;
    logic [63:0] e_pd;
    wb_entry_t   e;
    logic [68:0] w;
    #1;
    free = DEPTH - model_q.size();
    e_mr = (free >= 1);
    e_ar = (free >= (bus.mem_valid ? 2 : 1));
    chk("mem_ready", 64'(bus.mem_ready), 64'(e_mr));
    chk("alu_ready", 64'(bus.alu_ready), 64'(e_ar));
    model_pend(bus.query_rs, e_hit, e_pd);
    chk("pend_hit", 64'(bus.pend_hit), 64'(e_hit));
    chk("pend_data", bus.pend_data, e_pd);
    m_taken = bus.mem_valid && e_mr;
    a_taken = bus.alu_valid && e_ar;
    @(posedge clk);
    if (model_q.size() > 0) begin
      e = model_q.pop_front();
      m_out_valid = 1'b1;
      m_out_rd    = e.rd;
      m_out_data  = e.data;
    end else begin
      m_out_valid = 1'b0;
    end
    if (m_taken && bus.mem_rd != 5'd0) begin
      model_q.push_back('{rd: bus.mem_rd, data: bus.mem_data});
      exp_q.push_back({bus.mem_rd, bus.mem_data});
    end
    if (a_taken && bus.alu_rd != 5'd0) begin
      model_q.push_back('{rd: bus.alu_rd, data: bus.alu_data});
      exp_q.push_back({bus.alu_rd, bus.alu_data});
    end
    @(negedge clk);
    chk("reg_write", 64'(bus.reg_write), 64'(m_out_valid));
    chk("rd", 64'(bus.rd), 64'(m_out_rd));
    chk("write_data", bus.write_data, m_out_data);
    chk("count", 64'(bus.dbg_count), 64'(model_q.size()));
    if (bus.dbg_count > 8'(DEPTH)) chk("count_bound", 64'(bus.dbg_count), 64'(DEPTH));
    if (bus.reg_write) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 64'(bus.rd), 64'd0);
      end else begin
        w = exp_q.pop_front();
        chk("sb_rd", 64'(bus.rd), 64'(w[68:64]));
        chk("sb_data", bus.write_data, w[63:0]);
      end
    end
  endtask

  task automatic rand_offer(input bit force_valid, input bit m_taken, input bit a_taken);
    if (m_taken || !bus.mem_valid) begin
      bus.mem_valid = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
      bus.mem_rd    = 5'($urandom_range(force_valid ? 1 : 0, 7));
      bus.mem_data  = {$urandom, $urandom};
    end
    if (a_taken || !bus.alu_valid) begin
      bus.alu_valid = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
      bus.alu_rd    = 5'($urandom_range(force_valid ? 1 : 0, 7));
      bus.alu_data  = {$urandom, $urandom};
    end
    bus.query_rs = 5'($urandom_range(0, 8));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          mv;  logic [4:0] mrd; logic [63:0] mdata;
    bit          av;  logic [4:0] ard; logic [63:0] adata;
    logic [4:0]  q;
    bit          e_mr; bit e_ar; bit e_hit; logic [63:0] e_pd;
    bit          e_rw; logic [4:0] e_rd; logic [63:0] e_wd;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(bit mv, logic [4:0] mrd, logic [63:0] md,
                              bit av, logic [4:0] ard, logic [63:0] ad,
                              logic [4:0] q, bit mr, bit ar, bit hit, logic [63:0] pd,
                              bit rw, logic [4:0] rd, logic [63:0] wd);
    vec_t v;
    v.mv = mv; v.mrd = mrd; v.mdata = md;
    v.av = av; v.ard = ard; v.adata = ad;
    v.q = q; v.e_mr = mr; v.e_ar = ar; v.e_hit = hit; v.e_pd = pd;
    v.e_rw = rw; v.e_rd = rd; v.e_wd = wd;
    return v;
  endfunction

  bit mt, at;

  initial begin
    // single ALU push, then observe 2-cycle latency
    vecs[0]  = mk(0, 0, 0,       1, 5, 64'hA5,   0, 1, 1, 0, 0,        0, 0, 0);
    vecs[1]  = mk(0, 0, 0,       0, 0, 0,        5, 1, 1, 1, 64'hA5,   1, 5, 64'hA5);
    // same-cycle mem+alu to rd 3: mem is older
    vecs[2]  = mk(1, 3, 64'h11,  1, 3, 64'h22,   5, 1, 1, 1, 64'hA5,   0, 5, 64'hA5);
    vecs[3]  = mk(0, 0, 0,       0, 0, 0,        3, 1, 1, 1, 64'h22,   1, 3, 64'h11);
    vecs[4]  = mk(0, 0, 0,       0, 0, 0,        3, 1, 1, 1, 64'h22,   1, 3, 64'h22);
    vecs[5]  = mk(0, 0, 0,       0, 0, 0,        3, 1, 1, 1, 64'h22,   0, 3, 64'h22);
    vecs[6]  = mk(0, 0, 0,       0, 0, 0,        3, 1, 1, 0, 0,        0, 3, 64'h22);
    // fill to DEPTH-1, then contention for the last slot, alu retried
    vecs[7]  = mk(1, 1, 64'h1001, 1, 2, 64'h1002, 0, 1, 1, 0, 0,        0, 3, 64'h22);
    vecs[8]  = mk(1, 4, 64'h1004, 1, 6, 64'h1006, 2, 1, 1, 1, 64'h1002, 1, 1, 64'h1001);
    vecs[9]  = mk(1, 7, 64'h1007, 1, 8, 64'h1008, 1, 1, 0, 1, 64'h1001, 1, 2, 64'h1002);
    vecs[10] = mk(0, 0, 0,       1, 8, 64'h1008, 8, 1, 1, 0, 0,        1, 4, 64'h1004);
    vecs[11] = mk(0, 0, 0,       0, 0, 0,        8, 1, 1, 1, 64'h1008, 1, 6, 64'h1006);
    vecs[12] = mk(0, 0, 0,       0, 0, 0,        0, 1, 1, 0, 0,        1, 7, 64'h1007);
    vecs[13] = mk(0, 0, 0,       0, 0, 0,        4, 1, 1, 0, 0,        1, 8, 64'h1008);
    // rd==0 pushes are acknowledged and dropped
    vecs[14] = mk(1, 0, 64'hEE,  1, 0, 64'hFF,   8, 1, 1, 1, 64'h1008, 0, 8, 64'h1008);
    vecs[15] = mk(0, 0, 0,       0, 0, 0,        0, 1, 1, 0, 0,        0, 8, 64'h1008);
    vecs[16] = mk(0, 0, 0,       0, 0, 0,        8, 1, 1, 0, 0,        0, 8, 64'h1008);

    do_reset();

    for (int i = 0; i < NV; i++) begin
      bus.mem_valid = vecs[i].mv; bus.mem_rd = vecs[i].mrd; bus.mem_data = vecs[i].mdata;
      bus.alu_valid = vecs[i].av; bus.alu_rd = vecs[i].ard; bus.alu_data = vecs[i].adata;
      bus.query_rs  = vecs[i].q;
      #1;
      chk($sformatf("vec%0d_mem_ready", i), 64'(bus.mem_ready), 64'(vecs[i].e_mr));
      chk($sformatf("vec%0d_alu_ready", i), 64'(bus.alu_ready), 64'(vecs[i].e_ar));
      chk($sformatf("vec%0d_pend_hit", i), 64'(bus.pend_hit), 64'(vecs[i].e_hit));
      chk($sformatf("vec%0d_pend_data", i), bus.pend_data, vecs[i].e_pd);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_reg_write", i), 64'(bus.reg_write), 64'(vecs[i].e_rw));
      chk($sformatf("vec%0d_rd", i), 64'(bus.rd), 64'(vecs[i].e_rd));
      chk($sformatf("vec%0d_write_data", i), bus.write_data, vecs[i].e_wd);
    end

    // randomized traffic against the model
    do_reset();
    mt = 1'b1; at = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rand_offer(1'b1, mt, at);
      model_tick(mt, at);
    end
    for (int c = 0; c < 200; c++) begin
      rand_offer(1'b0, mt, at);
      model_tick(mt, at);
    end
    drive_idle();
    repeat (8) model_tick(mt, at);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // reset mid-stream with three entries queued
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_data = 64'hA10;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 64'hA11;
    model_tick(mt, at);
    bus.mem_rd = 5'd12; bus.mem_data = 64'hA12;
    bus.alu_rd = 5'd13; bus.alu_data = 64'hA13;
    model_tick(mt, at);
    chk("pre_rst_count", 64'(bus.dbg_count), 64'd3);
    drive_idle();
    bus.query_rs = 5'd12;
    reset = 1'b0;
    #1;
    chk("async_rst_reg_write", 64'(bus.reg_write), 64'd0);
    chk("async_rst_pend_hit", 64'(bus.pend_hit), 64'd0);
    chk("async_rst_rd", 64'(bus.rd), 64'd0);
    chk("async_rst_count", 64'(bus.dbg_count), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.query_rs = 5'(10 + (c % 4));
      model_tick(mt, at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
